// File: rtl/binom_seq.sv
// binom_seq: iterative nCr / nPr engine using a multiply then exact restoring divide loop.
module binom_seq #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             err
);
    localparam int CW = $clog2(2*WIDTH);
    typedef enum logic [2:0] {IDLE, CHECK, MUL, DIV, DONE} state_t;
    state_t               state;
    logic                 md;
    logic [WIDTH-1:0]     nn, rr, kk, ii, acc, rem;
    logic [2*WIDTH-1:0]   dq;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     nmr, kmin, factor, rnext, nacc;
    logic [2*WIDTH-1:0]   prod, qnext;
    logic [WIDTH:0]       t;
    logic                 ge, last, fin;
    always_comb begin
        nmr    = nn - rr;
        kmin   = md ? rr : (rr < nmr ? rr : nmr);
        factor = nn - kk + ii;
        prod   = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, factor};
        // dq holds the remaining dividend bits on top and collects quotient bits below
        t      = {rem, dq[2*WIDTH-1]};
        ge     = t >= {1'b0, ii};
        rnext  = ge ? WIDTH'(t - {1'b0, ii}) : t[WIDTH-1:0];
        qnext  = {dq[2*WIDTH-2:0], ge};
        last   = cnt == CW'(2*WIDTH-1);
        nacc   = (state == MUL) ? prod[WIDTH-1:0] : qnext[WIDTH-1:0];
        fin    = ii == kk;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            md     <= 1'b0;
            nn     <= '0;
            rr     <= '0;
            kk     <= '0;
            ii     <= '0;
            acc    <= '0;
            rem    <= '0;
            dq     <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    nn     <= n;
                    rr     <= r;
                    md     <= mode;
                    result <= '0;
                    ovf    <= 1'b0;
                    err    <= 1'b0;
                    busy   <= 1'b1;
                    state  <= CHECK;
                end
                CHECK: begin
                    kk  <= kmin;
                    acc <= WIDTH'(1);
                    ii  <= WIDTH'(1);
                    if (rr > nn) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (kmin == '0) begin
                        result <= WIDTH'(1);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (!md) begin
                        dq    <= prod;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end else if (prod[2*WIDTH-1:WIDTH] != '0) begin
                        ovf    <= 1'b1;
                        result <= '1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else if (fin) begin
                        result <= nacc;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        acc   <= nacc;
                        ii    <= ii + WIDTH'(1);
                        state <= MUL;
                    end
                end
                DIV: begin
                    dq  <= qnext;
                    rem <= rnext;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        if (qnext[2*WIDTH-1:WIDTH] != '0) begin
                            ovf    <= 1'b1;
                            result <= '1;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end else if (fin) begin
                            result <= nacc;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end else begin
                            acc   <= nacc;
                            ii    <= ii + WIDTH'(1);
                            state <= MUL;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_binom_seq.sv
// tb_binom_seq: directed checks of binom_seq results, flags, latency and handshake.
module tb_binom_seq;
    localparam int W = 36;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] n = '0;
    logic [W-1:0] r = '0;
    logic         busy, done, ovf, err;
    logic [W-1:0] result;
    int           total = 0;
    int           passed = 0;
    int           done_cnt = 0;
    int           lat;
    binom_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .n(n), .r(r),
        .busy(busy), .done(done), .result(result), .ovf(ovf), .err(err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask
    // Latency is counted as in the datasheet: done seen at edge T0+lat.
    task automatic run(input string tag, input logic m, input logic [W-1:0] nv, input logic [W-1:0] rv,
                       input logic hold, input logic poke, output int l);
        int c = 0;
        int d0;
        mode = m; n = nv; r = rv; start = 1'b1;
        @(posedge clk); #1;
        d0 = done_cnt;
        chk({tag, " busy"}, 64'(busy), 64'd1);
        if (!hold) start = 1'b0;
        n = W'($urandom); r = W'($urandom); mode = ~m;
        while (!done && c < 3000) begin
            @(posedge clk); #1;
            c++;
            if (poke) start = (c == 3);
        end
        start = 1'b0;
        chk({tag, " finished"}, 64'(done), 64'd1);
        chk({tag, " busy low at done"}, 64'(busy), 64'd0);
        l = c + 1;
        @(posedge clk); #1;
        chk({tag, " single done"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, " done pulse"}, 64'(done), 64'd0);
    endtask
    task automatic op(input string tag, input logic m, input logic [W-1:0] nv, input logic [W-1:0] rv,
                      input logic [W-1:0] er, input logic eo, input logic ee, input int el);
        run(tag, m, nv, rv, 1'b0, 1'b0, lat);
        chk({tag, " result"}, 64'(result), 64'(er));
        chk({tag, " ovf"}, 64'(ovf), 64'(eo));
        chk({tag, " err"}, 64'(err), 64'(ee));
        if (el > 0) chk({tag, " latency"}, 64'(lat), 64'(el));
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset flags", 64'({ovf, err}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op("C(5,2)", 1'b0, 5, 2, 10, 0, 0, 148);
        op("C(10,8)", 1'b0, 10, 8, 45, 0, 0, 148);
        op("C(7,7)", 1'b0, 7, 7, 1, 0, 0, 2);
        op("C(10,0)", 1'b0, 10, 0, 1, 0, 0, 2);
        op("C(3,5)", 1'b0, 3, 5, 0, 0, 1, 2);
        op("P(5,2)", 1'b1, 5, 2, 20, 0, 0, 4);
        op("P(12,12)", 1'b1, 12, 12, 479001600, 0, 0, 14);
        op("P(3,5)", 1'b1, 3, 5, 0, 0, 1, 2);
        op("P(2^35,2)", 1'b1, W'(64'd1 << 35), 2, 36'hFFFFFFFFF, 1, 0, 4);
        op("C(68,34)", 1'b0, 68, 34, 36'hFFFFFFFFF, 1, 0, 0);
        chk("C(68,34) early", 64'(lat < 2484), 64'd1);
        mode = 1'b0; n = 20; r = 10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        lat = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (800) @(posedge clk);
        #1;
        chk("rst no done", 64'(done_cnt - lat), 64'd0);
        op("C(20,10)", 1'b0, 20, 10, 184756, 0, 0, 732);
        run("hold P(6,3)", 1'b1, 6, 3, 1'b1, 1'b0, lat);
        chk("hold result", 64'(result), 64'd120);
        chk("hold latency", 64'(lat), 64'd5);
        run("poke C(6,2)", 1'b0, 6, 2, 1'b0, 1'b1, lat);
        chk("poke result", 64'(result), 64'd15);
        chk("poke latency", 64'(lat), 64'd148);
        op("b2b P(4,4)", 1'b1, 4, 4, 24, 0, 0, 6);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/binom_seq.md
# binom_seq

Parametrised, iterative combinatorics engine that computes either nCr or nPr for unsigned WIDTH-bit operands behind a start/done handshake. It replaces the free-running factorial/permutation/division chain with a single multiply-then-exact-divide loop. The loop uses the symmetry k = min(r, n-r) and performs no factorial expansion, so intermediate values stay within 2·WIDTH bits. It sits in the arithmetic datapath next to the existing division and factorial blocks and shares their clock.

## Interface
- WIDTH, 36, operand/result width in bits (≥ 4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = nCr, 1 = nPr
- n  in  WIDTH  unsigned n, latched on accepted start
- r  in  WIDTH  unsigned r, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; result/flags valid from this cycle
- result  out  WIDTH  answer; held until the next accepted start
- ovf  out  1  true result ≥ 2^WIDTH; result saturated to all ones
- err  out  1  r > n; result = 0

## Operation
- States: IDLE, CHECK, MUL, DIV, DONE.
- IDLE:
  - start=1 latches n, r and mode.
  - Clears result, ovf and err, then moves to CHECK.
  - start in any other state is ignored.
- CHECK (1 cycle):
  - If r > n: set err, result=0, go to DONE.
  - Otherwise k = mode ? r : min(r, n-r), acc=1, i=1.
  - If k==0: result=1, go to DONE. Otherwise go to MUL.
- MUL (1 cycle):
  - prod[2W-1:0] = acc × (n-k+i).
  - nPr, prod ≥ 2^WIDTH: set ovf, result = all ones, go to DONE.
  - nPr otherwise: acc = prod[W-1:0].
  - nCr: go to DIV with dividend = prod, divisor = i.
- DIV (exactly 2·WIDTH cycles, restoring, one quotient bit per cycle, MSB first):
  - The quotient is exact (remainder 0) by construction.
  - On the last cycle, if quotient[2W-1:W] ≠ 0: set ovf, result = all ones, go to DONE.
  - Otherwise acc = quotient[W-1:0].
- Loop control, applied after MUL (nPr) or the last DIV cycle (nCr):
  - If i == k: result = acc, go to DONE.
  - Otherwise i = i+1, go to MUL.
- DONE (1 cycle): done=1, busy=0, then IDLE. A start on this cycle is ignored.
- All arithmetic is unsigned. The i and k counters are WIDTH bits. n-k+i never exceeds n.

## Timing
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, ovf=0, err=0. Any in-flight computation is discarded with no done pulse.
- Accepted start at edge T0 sets busy=1 from T0.
- done is asserted in the cycle following the final state:
  - nCr: done at T0 + 1 + k·(1 + 2·WIDTH) + 1 (148 cycles for k=2, WIDTH=36).
  - nPr: done at T0 + 1 + k + 1.
  - err or k==0: done at T0 + 2.
  - Overflow: done one cycle after the detecting MUL or DIV cycle.
- The earliest next start is accepted on the cycle after done, i.e. in IDLE.
- Input changes while busy have no effect.

## Test plan
- nCr, n=5, r=2, WIDTH=36 → done at T0+148, result=10, ovf=0, err=0. n=10, r=8 → result=45, same latency as r=2 (symmetry).
- k==0 and r>n:
  - n=7, r=7 → result=1 at T0+2.
  - n=10, r=0 → result=1 at T0+2.
  - n=3, r=5 → err=1, result=0 at T0+2.
- nPr, n=5, r=2 → done at T0+4, result=20. n=12, r=12 → result=479001600 at T0+14.
- Overflow:
  - nCr, n=68, r=34 → ovf=1, result=0xFFFFFFFFF, early termination before k iterations.
  - nPr, n=2^35, r=2 → ovf=1 at the second MUL.
- Reset mid-operation: assert rst_n=0 during DIV of C(20,10) → outputs zero immediately, no done pulse. Restart C(20,10) → 184756.
- Protocol:
  - start held high through a whole operation → exactly one done per accepted start.
  - start pulsed while busy → ignored.
  - Back-to-back start on the cycle after done → accepted.
